// File: rtl/elliptic_curve_structs.sv
// Shared types for the ECDSA verify path: signature layout, curve order and
// the controller state encoding (visible to the wrapper and the bench).
package elliptic_curve_structs;

    localparam int SIG_W = 16;

    typedef struct packed {
        logic [SIG_W-1:0] r;
        logic [SIG_W-1:0] s;
    } signature_t;

    typedef struct packed {
        logic [SIG_W-1:0] n;
    } curve_params_t;

    // Curve order n; r and s must both lie in [1, n-1].
    localparam curve_params_t params = '{n: 16'hFFF1};

    typedef enum logic [2:0] {
        IDLE,
        CHECK_RANGE,
        WAIT_HASH,
        WAIT_VERIFY,
        FINISH
    } verify_state_t;

endpackage

// File: rtl/ecdsa_sig_range_check.sv
// Combinational check that both signature scalars lie in [1, n-1].
// The comparisons are unsigned over the full field width.
module ecdsa_sig_range_check
    import elliptic_curve_structs::*;
(
    input  signature_t       sig,
    input  logic [SIG_W-1:0] n,
    output logic             in_range
);

    // Both scalars must be non-zero and strictly below the curve order.
    always_comb begin
        in_range = (sig.r != '0) && (sig.s != '0) && (sig.r < n) && (sig.s < n);
    end

endmodule

// File: rtl/ecdsa_verify_control.sv
// ECDSA verification sequencer: latches (r, s), range-checks it, drives the
// hash and verify datapath, and reports a verdict. A per-wait-state watchdog
// aborts with error=1 if the datapath never answers.
module ecdsa_verify_control
    import elliptic_curve_structs::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       master_reset_n,
    input  logic       init,
    input  signature_t received_signature,
    input  logic       done_hash,
    input  logic       done_verify_math,
    input  logic       x1_match,
    output logic       start_hash,
    output logic       load_hash,
    output logic       start_verify,
    output signature_t sig_out,
    output logic       reset,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       error
);

    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    verify_state_t state, state_nxt;
    logic [CW-1:0] wd_cnt;
    logic          sig_ok;
    logic          wd_expired;
    logic          in_wait;
    logic          wait_entry;

    ecdsa_sig_range_check u_range (
        .sig      (sig_out),
        .n        (params.n),
        .in_range (sig_ok)
    );

    assign wd_expired = (wd_cnt == CNT_MAX);
    assign in_wait    = (state == WAIT_HASH) || (state == WAIT_VERIFY);
    // Any transition into a wait state (including WAIT_HASH -> WAIT_VERIFY)
    // restarts the watchdog so each wait gets its own full budget.
    assign wait_entry = (state_nxt != state) &&
                        ((state_nxt == WAIT_HASH) || (state_nxt == WAIT_VERIFY));

    // State register.
    always_ff @(posedge clk or negedge master_reset_n) begin
        if (!master_reset_n) state <= IDLE;
        else                 state <= state_nxt;
    end

    // Next-state and output decode; a done input beats a same-cycle timeout.
    always_comb begin
        state_nxt    = state;
        start_hash   = 1'b0;
        load_hash    = 1'b0;
        start_verify = 1'b0;
        done         = 1'b0;
        reset        = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (init) state_nxt = CHECK_RANGE;
            end
            CHECK_RANGE: begin
                if (sig_ok) begin
                    start_hash = 1'b1;
                    state_nxt  = WAIT_HASH;
                end else begin
                    state_nxt  = FINISH;
                end
            end
            WAIT_HASH: begin
                if (done_hash) begin
                    load_hash    = 1'b1;
                    start_verify = 1'b1;
                    state_nxt    = WAIT_VERIFY;
                end else if (wd_expired) begin
                    state_nxt    = FINISH;
                end
            end
            WAIT_VERIFY: begin
                if (done_verify_math || wd_expired) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                reset     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Watchdog: clears on wait-state entry, counts while waiting, saturates.
    always_ff @(posedge clk or negedge master_reset_n) begin
        if (!master_reset_n)           wd_cnt <= '0;
        else if (wait_entry)           wd_cnt <= '0;
        else if (in_wait && !wd_expired) wd_cnt <= wd_cnt + 1'b1;
    end

    // Signature latch and verdict registers; held until the next accepted init.
    always_ff @(posedge clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            sig_out <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else if (state == IDLE && init) begin
            sig_out <= received_signature;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else if (state == WAIT_VERIFY && done_verify_math) begin
            valid   <= x1_match;
        end else if (((state == WAIT_HASH && !done_hash) || state == WAIT_VERIFY) && wd_expired) begin
            valid   <= 1'b0;
            error   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ecdsa_verify_control.sv
// Directed bench for ecdsa_verify_control: expected verdicts and done cycles
// are queued when each run is launched and matched against observed done pulses.
module tb_ecdsa_verify_control;
    import elliptic_curve_structs::*;

    localparam int TO = 48;

    typedef struct {
        logic v;
        logic e;
        int   c;
    } res_t;

    logic       clk = 1'b0;
    logic       master_reset_n = 1'b1;
    logic       init = 1'b0;
    logic       done_hash = 1'b0;
    logic       done_verify_math = 1'b0;
    logic       x1_match = 1'b0;
    signature_t received_signature = '0;
    logic       start_hash, load_hash, start_verify, reset, busy, done, valid, error;
    signature_t sig_out;

    int   cyc = 0;
    int   sh_cnt = 0, lh_cnt = 0, sv_cnt = 0, done_cnt = 0;
    int   n_assert = 0, n_fail = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    logic [SIG_W-1:0] nn;
    int t0, s0, l0, v0, d0;

    ecdsa_verify_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .master_reset_n     (master_reset_n),
        .init               (init),
        .received_signature (received_signature),
        .done_hash          (done_hash),
        .done_verify_math   (done_verify_math),
        .x1_match           (x1_match),
        .start_hash         (start_hash),
        .load_hash          (load_hash),
        .start_verify       (start_verify),
        .sig_out            (sig_out),
        .reset              (reset),
        .busy               (busy),
        .done               (done),
        .valid              (valid),
        .error              (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts pulses and records every done with its verdict and cycle.
    always @(negedge clk) begin
        if (start_hash)   sh_cnt <= sh_cnt + 1;
        if (load_hash)    lh_cnt <= lh_cnt + 1;
        if (start_verify) sv_cnt <= sv_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            obs_q.push_back('{v: valid, e: error, c: cyc});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [SIG_W-1:0] r, input logic [SIG_W-1:0] s, output int t);
        t = cyc;
        received_signature = '{r: r, s: s};
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    task automatic pulse_dh(input int c);
        at(c);
        done_hash = 1'b1;
        @(posedge clk);
        #1;
        done_hash = 1'b0;
    endtask

    task automatic pulse_dv(input int c, input logic m);
        at(c);
        done_verify_math = 1'b1;
        x1_match = m;
        @(posedge clk);
        #1;
        done_verify_math = 1'b0;
        x1_match = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int prev, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (done_cnt > prev) break;
            @(posedge clk);
            #1;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > prev), 64'd1);
    endtask

    task automatic check_done(input string tag);
        res_t e, o;
        if (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_valid"}, 64'(o.v), 64'(e.v));
            chk({tag, "_error"}, 64'(o.e), 64'(e.e));
            chk({tag, "_done_cycle"}, 64'(o.c), 64'(e.c));
        end else begin
            chk({tag, "_scoreboard_pair"}, 64'(obs_q.size()), 64'd1);
        end
    endtask

    initial begin
        nn = params.n;

        // Reset state
        #2 master_reset_n = 1'b0;
        #2;
        chk("reset_outs", 64'({start_hash, load_hash, start_verify, reset, busy, done, valid, error}), 64'd0);
        chk("reset_sig", 64'(sig_out), 64'd0);
        repeat (3) @(posedge clk);
        #1 master_reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Valid signature, with an ignored init during WAIT_VERIFY
        s0 = sh_cnt; l0 = lh_cnt; v0 = sv_cnt; d0 = done_cnt;
        start_run(16'd5, 16'd7, t0);
        exp_q.push_back('{v: 1'b1, e: 1'b0, c: t0 + 54});
        chk("ok_sig_latched", 64'(sig_out), 64'({16'd5, 16'd7}));
        chk("ok_start_hash", 64'(start_hash), 64'd1);
        chk("ok_busy", 64'(busy), 64'd1);
        pulse_dh(t0 + 12);
        at(t0 + 20);
        received_signature = '{r: 16'd9, s: 16'd9};
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        at(t0 + 22);
        chk("busy_init_ignored_sig", 64'(sig_out), 64'({16'd5, 16'd7}));
        chk("busy_init_ignored_busy", 64'(busy), 64'd1);
        pulse_dv(t0 + 53, 1'b1);
        wait_done("ok", d0, 80);
        check_done("ok");
        chk("ok_start_hash_once", 64'(sh_cnt - s0), 64'd1);
        chk("ok_load_hash_once", 64'(lh_cnt - l0), 64'd1);
        chk("ok_start_verify_once", 64'(sv_cnt - v0), 64'd1);
        chk("ok_done_once", 64'(done_cnt - d0), 64'd1);
        chk("ok_valid_held", 64'(valid), 64'd1);

        // Bad match, launched right after the previous done
        d0 = done_cnt;
        start_run(16'd5, 16'd7, t0);
        exp_q.push_back('{v: 1'b0, e: 1'b0, c: t0 + 54});
        chk("new_init_clears_valid", 64'(valid), 64'd0);
        pulse_dh(t0 + 12);
        pulse_dv(t0 + 53, 1'b0);
        wait_done("bad", d0, 80);
        check_done("bad");

        // Range reject: r = 0
        s0 = sh_cnt; d0 = done_cnt;
        start_run(16'd0, 16'd7, t0);
        exp_q.push_back('{v: 1'b0, e: 1'b0, c: t0 + 2});
        wait_done("rej_r0", d0, 10);
        check_done("rej_r0");
        chk("rej_r0_no_hash", 64'(sh_cnt - s0), 64'd0);

        // Range reject: s = n
        s0 = sh_cnt; d0 = done_cnt;
        start_run(16'd5, nn, t0);
        exp_q.push_back('{v: 1'b0, e: 1'b0, c: t0 + 2});
        wait_done("rej_sn", d0, 10);
        check_done("rej_sn");
        chk("rej_sn_no_hash", 64'(sh_cnt - s0), 64'd0);

        // Watchdog in WAIT_HASH, r = s = n-1 (upper boundary, accepted)
        s0 = sh_cnt; l0 = lh_cnt; d0 = done_cnt;
        start_run(nn - 16'd1, nn - 16'd1, t0);
        exp_q.push_back('{v: 1'b0, e: 1'b1, c: t0 + TO + 2});
        wait_done("wd_hash", d0, TO + 10);
        check_done("wd_hash");
        chk("wd_hash_started", 64'(sh_cnt - s0), 64'd1);
        chk("wd_hash_no_load", 64'(lh_cnt - l0), 64'd0);
        chk("wd_error_held", 64'(error), 64'd1);

        // done_hash on the final count cycle wins over the timeout
        d0 = done_cnt;
        start_run(16'd3, 16'd4, t0);
        exp_q.push_back('{v: 1'b1, e: 1'b0, c: t0 + TO + 3});
        chk("new_init_clears_error", 64'(error), 64'd0);
        pulse_dh(t0 + TO + 1);
        pulse_dv(t0 + TO + 2, 1'b1);
        wait_done("wd_edge", d0, 20);
        check_done("wd_edge");

        // Watchdog in WAIT_VERIFY; x1_match alone must not set valid
        d0 = done_cnt;
        start_run(16'd2, 16'd2, t0);
        exp_q.push_back('{v: 1'b0, e: 1'b1, c: t0 + TO + 6});
        pulse_dh(t0 + 5);
        x1_match = 1'b1;
        wait_done("wd_verify", d0, TO + 20);
        x1_match = 1'b0;
        check_done("wd_verify");

        // Async reset mid-WAIT_VERIFY, off a clock edge
        d0 = done_cnt;
        start_run(16'd11, 16'd12, t0);
        pulse_dh(t0 + 3);
        at(t0 + 8);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 master_reset_n = 1'b0;
        #1;
        chk("async_reset_outs", 64'({start_hash, load_hash, start_verify, reset, busy, done, valid, error}), 64'd0);
        chk("async_reset_sig", 64'(sig_out), 64'd0);
        at(t0 + 11);
        master_reset_n = 1'b1;
        at(t0 + 14);
        chk("async_reset_no_done", 64'(done_cnt - d0), 64'd0);

        // Normal run after reset, minimum-latency datapath
        d0 = done_cnt;
        start_run(nn - 16'd1, 16'd1, t0);
        exp_q.push_back('{v: 1'b1, e: 1'b0, c: t0 + 4});
        pulse_dh(t0 + 2);
        pulse_dv(t0 + 3, 1'b1);
        wait_done("post_reset", d0, 20);
        check_done("post_reset");
        chk("scoreboard_drained", 64'(exp_q.size() + obs_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
